// File: rtl/hbm_bringup_seq.sv
// ---------------------------------------------------------------------------
// hbm_bringup_seq
//
// Purpose:
//   Reset and bring-up sequencer for the HBM2e subsystem. It pulses the IOPLL
//   reset, waits for a filtered lock, releases the NoC reset, waits for HBM
//   calibration and finally releases the AXI reset. Failed attempts are
//   retried up to MAX_RETRIES times, after which a sticky fault is latched.
//   A catastrophic-temperature trip forces the fault state at once.
//
// Optional feature (macro HBM_BRINGUP_THERMAL_MON_EN):
//   When defined, hbm_temp is synchronised and compared against TEMP_WARN to
//   drive thermal_warn, and a warning stalls the AXI_RST -> RUN transition.
//   When undefined, hbm_temp is ignored and thermal_warn is tied low.
//
// Ports:
//   clk100_in_clk        in   100 MHz system clock
//   rst_in_reset_n       in   asynchronous active-low reset
//   iopll_locked_export  in   PLL lock (async, 2-flop synchronised)
//   hbm_cal_success      in   calibration success (2-flop synchronised)
//   hbm_cal_fail         in   calibration failure (2-flop synchronised)
//   hbm_cattrip          in   catastrophic temperature trip (2-flop synchronised)
//   hbm_temp       [2:0] in   HBM temperature code
//   iopll_reset_reset    out  active-high PLL reset
//   noc_reset_in_reset   out  active-high NoC reset
//   axi_reset_in_reset   out  active-high AXI reset
//   sys_ready            out  RUN state reached
//   sys_fail             out  terminal fault, sticky until reset
//   fail_cause     [1:0] out  0 none, 1 lock timeout/loss, 2 cal fail/timeout, 3 cattrip
//   retry_cnt      [1:0] out  attempts consumed (saturating)
//   seq_state      [2:0] out  current state encoding
//   thermal_warn         out  synced temp >= TEMP_WARN (feature build only)
// ---------------------------------------------------------------------------
module hbm_bringup_seq #(
    parameter int          PLL_RST_CYCLES = 16,
    parameter int          LOCK_FILT      = 8,
    parameter int          LOCK_TIMEOUT   = 65535,
    parameter int          NOC_HOLD       = 32,
    parameter int          CAL_TIMEOUT    = 16777215,
    parameter int          AXI_HOLD       = 32,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [2:0]  TEMP_WARN      = 3'd5
) (
    input  logic       clk100_in_clk,
    input  logic       rst_in_reset_n,
    input  logic       iopll_locked_export,
    input  logic       hbm_cal_success,
    input  logic       hbm_cal_fail,
    input  logic       hbm_cattrip,
    input  logic [2:0] hbm_temp,
    output logic       iopll_reset_reset,
    output logic       noc_reset_in_reset,
    output logic       axi_reset_in_reset,
    output logic       sys_ready,
    output logic       sys_fail,
    output logic [1:0] fail_cause,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state,
    output logic       thermal_warn
);

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = imax(imax(imax(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                       imax(NOC_HOLD, CAL_TIMEOUT)), AXI_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int FW = $clog2(LOCK_FILT + 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        NOC_RST   = 3'd2,
        WAIT_CAL  = 3'd3,
        AXI_RST   = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [FW-1:0] filt, filt_nxt;
    logic [1:0]    retry_nxt, cause_nxt, fail_code;
    logic          attempt_fail;
    logic          stall;

    logic lock_s1, lock_s2, succ_s1, succ_s2, calf_s1, calf_s2, trip_s1, trip_s2;

    // Every state entry reloads the shared counter; the state is left when it
    // reaches zero, so a load of N-1 gives exactly N cycles in the state.
    function automatic logic [CW-1:0] reload(state_t s);
        case (s)
            PLL_RST:   return CW'(PLL_RST_CYCLES - 1);
            WAIT_LOCK: return CW'(LOCK_TIMEOUT - 1);
            NOC_RST:   return CW'(NOC_HOLD - 1);
            WAIT_CAL:  return CW'(CAL_TIMEOUT - 1);
            AXI_RST:   return CW'(AXI_HOLD - 1);
            default:   return '0;
        endcase
    endfunction

    always_ff @(posedge clk100_in_clk or negedge rst_in_reset_n) begin
        if (!rst_in_reset_n) begin
            lock_s1 <= 1'b0; lock_s2 <= 1'b0;
            succ_s1 <= 1'b0; succ_s2 <= 1'b0;
            calf_s1 <= 1'b0; calf_s2 <= 1'b0;
            trip_s1 <= 1'b0; trip_s2 <= 1'b0;
        end else begin
            lock_s1 <= iopll_locked_export; lock_s2 <= lock_s1;
            succ_s1 <= hbm_cal_success;     succ_s2 <= succ_s1;
            calf_s1 <= hbm_cal_fail;        calf_s2 <= calf_s1;
            trip_s1 <= hbm_cattrip;         trip_s2 <= trip_s1;
        end
    end

`ifdef HBM_BRINGUP_THERMAL_MON_EN
    logic [2:0] temp_s1, temp_s2;
    logic       warn_q;

    always_ff @(posedge clk100_in_clk or negedge rst_in_reset_n) begin
        if (!rst_in_reset_n) begin
            temp_s1 <= 3'd0;
            temp_s2 <= 3'd0;
            warn_q  <= 1'b0;
        end else begin
            temp_s1 <= hbm_temp;
            temp_s2 <= temp_s1;
            warn_q  <= (temp_s2 >= TEMP_WARN);
        end
    end

    assign stall        = warn_q;
    assign thermal_warn = warn_q;
`else
    logic unused_temp;
    assign unused_temp  = ^{hbm_temp, TEMP_WARN};
    assign stall        = 1'b0;
    assign thermal_warn = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        filt_nxt     = filt;
        retry_nxt    = retry_cnt;
        cause_nxt    = fail_cause;
        attempt_fail = 1'b0;
        fail_code    = 2'd0;

        case (state)
            PLL_RST: begin
                if (cnt == '0) state_nxt = WAIT_LOCK;
                else           cnt_nxt   = cnt - 1'b1;
            end
            WAIT_LOCK: begin
                // Filter only advances on consecutive highs; acceptance beats timeout.
                if (lock_s2) begin
                    if (filt == FW'(LOCK_FILT - 1)) state_nxt = NOC_RST;
                    else                            filt_nxt  = filt + 1'b1;
                end else begin
                    filt_nxt = '0;
                end
                if (state_nxt == WAIT_LOCK) begin
                    if (cnt == '0) begin
                        attempt_fail = 1'b1;
                        fail_code    = 2'd1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            NOC_RST: begin
                if (!lock_s2)        begin attempt_fail = 1'b1; fail_code = 2'd1; end
                else if (cnt == '0)  state_nxt = WAIT_CAL;
                else                 cnt_nxt   = cnt - 1'b1;
            end
            WAIT_CAL: begin
                // Calibration fail outranks a simultaneous success.
                if (!lock_s2)        begin attempt_fail = 1'b1; fail_code = 2'd1; end
                else if (calf_s2)    begin attempt_fail = 1'b1; fail_code = 2'd2; end
                else if (succ_s2)    state_nxt = AXI_RST;
                else if (cnt == '0)  begin attempt_fail = 1'b1; fail_code = 2'd2; end
                else                 cnt_nxt   = cnt - 1'b1;
            end
            AXI_RST: begin
                // A thermal warning parks the counter at zero until it clears.
                if (!lock_s2)        begin attempt_fail = 1'b1; fail_code = 2'd1; end
                else if (cnt != '0)  cnt_nxt   = cnt - 1'b1;
                else if (!stall)     state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s2)        begin attempt_fail = 1'b1; fail_code = 2'd1; end
            end
            FAIL: ;
            default: state_nxt = PLL_RST;
        endcase

        if (attempt_fail) begin
            cause_nxt = fail_code;
            if (int'(retry_cnt) < MAX_RETRIES) begin
                if (retry_cnt != 2'd3) retry_nxt = retry_cnt + 1'b1;
                state_nxt = PLL_RST;
            end else begin
                state_nxt = FAIL;
            end
        end

        // Cattrip overrides everything else and is never retried.
        if (trip_s2 && state != FAIL) begin
            state_nxt = FAIL;
            cause_nxt = 2'd3;
        end

        if (state_nxt != state)     cnt_nxt  = reload(state_nxt);
        if (state_nxt != WAIT_LOCK) filt_nxt = '0;
    end

    // Outputs are decoded from the next state so they move with seq_state.
    always_ff @(posedge clk100_in_clk or negedge rst_in_reset_n) begin
        if (!rst_in_reset_n) begin
            state              <= PLL_RST;
            cnt                <= CW'(PLL_RST_CYCLES - 1);
            filt               <= '0;
            retry_cnt          <= 2'd0;
            fail_cause         <= 2'd0;
            iopll_reset_reset  <= 1'b1;
            noc_reset_in_reset <= 1'b1;
            axi_reset_in_reset <= 1'b1;
            sys_ready          <= 1'b0;
            sys_fail           <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            filt               <= filt_nxt;
            retry_cnt          <= retry_nxt;
            fail_cause         <= cause_nxt;
            iopll_reset_reset  <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
            noc_reset_in_reset <= (state_nxt == PLL_RST) || (state_nxt == WAIT_LOCK) ||
                                  (state_nxt == NOC_RST) || (state_nxt == FAIL);
            axi_reset_in_reset <= (state_nxt != RUN);
            sys_ready          <= (state_nxt == RUN);
            sys_fail           <= (state_nxt == FAIL);
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_hbm_bringup_seq.sv
module tb_hbm_bringup_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lock, cal_ok, cal_bad, trip;
    logic [2:0] temp;
    logic       iopll_rst, noc_rst, axi_rst, ready, sfail, twarn;
    logic [1:0] cause, retries;
    logic [2:0] st;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    hbm_bringup_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_FILT(3),
        .LOCK_TIMEOUT(50),
        .NOC_HOLD(4),
        .CAL_TIMEOUT(100),
        .AXI_HOLD(4),
        .MAX_RETRIES(2),
        .TEMP_WARN(3'd5)
    ) dut (
        .clk100_in_clk(clk),
        .rst_in_reset_n(rst_n),
        .iopll_locked_export(lock),
        .hbm_cal_success(cal_ok),
        .hbm_cal_fail(cal_bad),
        .hbm_cattrip(trip),
        .hbm_temp(temp),
        .iopll_reset_reset(iopll_rst),
        .noc_reset_in_reset(noc_rst),
        .axi_reset_in_reset(axi_rst),
        .sys_ready(ready),
        .sys_fail(sfail),
        .fail_cause(cause),
        .retry_cnt(retries),
        .seq_state(st),
        .thermal_warn(twarn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to edge number t after reset release; sampling is 1 ns past the edge.
    task automatic to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iopll"}, 32'(iopll_rst), 1);
        chk({tag, "_noc"},   32'(noc_rst),   1);
        chk({tag, "_axi"},   32'(axi_rst),   1);
        chk({tag, "_ready"}, 32'(ready),     0);
        chk({tag, "_fail"},  32'(sfail),     0);
        chk({tag, "_cause"}, 32'(cause),     0);
        chk({tag, "_retry"}, 32'(retries),   0);
        chk({tag, "_state"}, 32'(st),        0);
        chk({tag, "_warn"},  32'(twarn),     0);
    endtask

    initial begin
        rst_n = 1'b0; lock = 1'b0; cal_ok = 1'b0; cal_bad = 1'b0; trip = 1'b0; temp = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        // 1: normal bring-up, lock at cycle 10, cal success at cycle 40
        apply_reset();
        to(4);  chk("t1_wl_state", 32'(st), 1); chk("t1_wl_iopll", 32'(iopll_rst), 0);
                chk("t1_wl_noc", 32'(noc_rst), 1);
        to(10); lock = 1'b1;
        to(14); chk("t1_filt_state", 32'(st), 1);
        to(15); chk("t1_noc_state", 32'(st), 2); chk("t1_noc_rst", 32'(noc_rst), 1);
        to(18); chk("t1_noc_hold", 32'(st), 2);
        to(19); chk("t1_cal_state", 32'(st), 3); chk("t1_cal_noc", 32'(noc_rst), 0);
                chk("t1_cal_axi", 32'(axi_rst), 1);
        to(40); cal_ok = 1'b1;
        to(42); chk("t1_cal_sync", 32'(st), 3);
        to(43); chk("t1_axi_state", 32'(st), 4); chk("t1_axi_rst", 32'(axi_rst), 1);
        to(46); chk("t1_axi_hold", 32'(st), 4);
        to(47); chk("t1_run_state", 32'(st), 5); chk("t1_run_ready", 32'(ready), 1);
                chk("t1_run_axi", 32'(axi_rst), 0); chk("t1_run_retry", 32'(retries), 0);
                chk("t1_run_iopll", 32'(iopll_rst), 0);

        // 2: two-cycle lock glitch must not be accepted
        lock = 1'b0; cal_ok = 1'b0;
        apply_reset();
        to(5);  lock = 1'b1;
        to(7);  lock = 1'b0;
        to(10); chk("t2_glitch_state", 32'(st), 1);
        to(12); lock = 1'b1;
        to(16); chk("t2_two_highs", 32'(st), 1);
        to(17); chk("t2_noc_state", 32'(st), 2);

        // 2b: lock never arrives -> timeout, retry with cause 1
        lock = 1'b0;
        apply_reset();
        to(53); chk("t2b_wait_state", 32'(st), 1); chk("t2b_wait_retry", 32'(retries), 0);
        to(54); chk("t2b_to_state", 32'(st), 0); chk("t2b_to_retry", 32'(retries), 1);
                chk("t2b_to_cause", 32'(cause), 1); chk("t2b_to_iopll", 32'(iopll_rst), 1);

        // 3: cal fail (with simultaneous success) on every attempt -> FAIL
        lock = 1'b1; cal_ok = 1'b1; cal_bad = 1'b1;
        apply_reset();
        to(11); chk("t3_a1_cal", 32'(st), 3);
        to(12); chk("t3_a1_state", 32'(st), 0); chk("t3_a1_retry", 32'(retries), 1);
                chk("t3_a1_cause", 32'(cause), 2);
        to(23); chk("t3_a2_cal", 32'(st), 3);
        to(24); chk("t3_a2_state", 32'(st), 0); chk("t3_a2_retry", 32'(retries), 2);
        to(35); chk("t3_a3_cal", 32'(st), 3);
        to(36); chk("t3_fail_state", 32'(st), 6); chk("t3_fail_flag", 32'(sfail), 1);
                chk("t3_fail_cause", 32'(cause), 2); chk("t3_fail_retry", 32'(retries), 2);
                chk("t3_fail_iopll", 32'(iopll_rst), 1); chk("t3_fail_noc", 32'(noc_rst), 1);
                chk("t3_fail_axi", 32'(axi_rst), 1); chk("t3_fail_ready", 32'(ready), 0);
        to(40); chk("t3_fail_sticky", 32'(st), 6);

        // 4: lock lost while running
        lock = 1'b1; cal_ok = 1'b1; cal_bad = 1'b0;
        apply_reset();
        to(12); chk("t4_axi_state", 32'(st), 4);
        to(16); chk("t4_run_state", 32'(st), 5); chk("t4_run_ready", 32'(ready), 1);
                chk("t4_run_noc", 32'(noc_rst), 0);
        to(18); lock = 1'b0;
        to(20); chk("t4_pre_loss", 32'(ready), 1);
        to(21); chk("t4_loss_state", 32'(st), 0); chk("t4_loss_ready", 32'(ready), 0);
                chk("t4_loss_retry", 32'(retries), 1); chk("t4_loss_cause", 32'(cause), 1);
                chk("t4_loss_iopll", 32'(iopll_rst), 1); chk("t4_loss_axi", 32'(axi_rst), 1);

        // 5: cattrip together with cal success in WAIT_CAL, then async reset
        lock = 1'b1; cal_ok = 1'b0;
        apply_reset();
        to(14); trip = 1'b1; cal_ok = 1'b1;
        to(16); chk("t5_cal_state", 32'(st), 3);
        to(17); chk("t5_trip_state", 32'(st), 6); chk("t5_trip_cause", 32'(cause), 3);
                chk("t5_trip_fail", 32'(sfail), 1); chk("t5_trip_retry", 32'(retries), 0);
                chk("t5_trip_axi", 32'(axi_rst), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t5_async");
        trip = 1'b0; cal_ok = 1'b0;

        // 6: hot HBM while in AXI_RST
        lock = 1'b1; cal_ok = 1'b1; temp = 3'd6;
        apply_reset();
`ifdef HBM_BRINGUP_THERMAL_MON_EN
        to(3);  chk("t6_warn_on", 32'(twarn), 1);
        to(16); chk("t6_stall_state", 32'(st), 4);
        to(20); temp = 3'd2; chk("t6_stall_more", 32'(st), 4);
        to(23); chk("t6_warn_off", 32'(twarn), 0); chk("t6_still_axi", 32'(st), 4);
        to(24); chk("t6_run_state", 32'(st), 5); chk("t6_run_ready", 32'(ready), 1);
`else
        to(15); chk("t6_axi_state", 32'(st), 4);
        to(16); chk("t6_nostall_run", 32'(st), 5); chk("t6_warn_tied", 32'(twarn), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
